// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W / ADDR_W / NUM_REGS : default datapath and scoreboard sizes
//   MAX_WAIT                   : consecutive ALU denials before the ALU gets priority
//   REG_ZERO                   : hard-wired zero register (writes are dropped)
//   arb_state_t                : tie-break state of the arbiter
package rf_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned MAX_WAIT = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard for read-after-write hazard detection.
//   clk, reset            : clock, synchronous active-high reset
//   flush_i               : clears every pending bit
//   set_valid_i/set_addr_i: an instruction writing set_addr_i was issued
//   clr_valid_i/clr_addr_i: the register file is committing clr_addr_i
//   rs1_addr_i/rs2_addr_i : query addresses
//   rs1_busy_o/rs2_busy_o : pending bit of the queried register (x0 never busy)
module rf_scoreboard #(
  parameter int unsigned ADDR_W   = rf_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              set_valid_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);
  import rf_pkg::*;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Set is applied after clear so a new producer issued on the commit edge stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) pending_d[clr_addr_i] = 1'b0;
    if (set_valid_i) pending_d[set_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
    if (flush_i) pending_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Plain reads of the pending vector: no bypass from the commit stage.
  assign rs1_busy_o = (rs1_addr_i != ADDR_W'(REG_ZERO)) && pending_q[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != ADDR_W'(REG_ZERO)) && pending_q[rs2_addr_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the load
// unit, registers the winning write, and tracks pending destinations.
//   clk, reset                      : clock, synchronous active-high reset
//   flush                           : drops in-flight writes, clears scoreboard and arbiter
//   alu_valid/addr/data, alu_ready  : ALU writeback handshake
//   mem_valid/addr/data, mem_ready  : load writeback handshake
//   issue_valid, issue_rd           : marks issue_rd as pending
//   rs1_addr/rs2_addr, rs1/rs2_busy : hazard queries
//   rf_write_addr/data, rf_reg_write: register file write port
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W   = rf_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = rf_pkg::NUM_REGS,
  parameter int unsigned MAX_WAIT = rf_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write
);
  import rf_pkg::*;

  localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT - 1);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              alu_grant, mem_grant, alu_denied;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic              rf_we_q;

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEM_PRI;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grant, starvation counter and tie-break state.
  always_comb begin
    alu_grant  = 1'b0;
    mem_grant  = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (!reset && !flush) begin
      if (alu_valid && mem_valid) begin
        if (state_q == ALU_PRI) alu_grant = 1'b1;
        else                    mem_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end

    alu_denied = alu_valid && !alu_grant;

    if (alu_grant || !alu_valid)  wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    case (state_q)
      MEM_PRI: if (alu_denied && (wait_cnt_q == WAIT_SAT)) state_d = ALU_PRI;
      ALU_PRI: if (alu_grant) state_d = MEM_PRI;
      default: state_d = MEM_PRI;
    endcase

    if (flush) begin
      state_d    = MEM_PRI;
      wait_cnt_d = '0;
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign win_addr  = alu_grant ? alu_addr : mem_addr;
  assign win_data  = alu_grant ? alu_data : mem_data;

  // Output stage: x0 writes are accepted but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rf_we_q   <= 1'b0;
    end else begin
      rf_we_q <= (alu_grant || mem_grant) && (win_addr != ADDR_W'(REG_ZERO));
      if (alu_grant || mem_grant) begin
        rf_addr_q <= win_addr;
        rf_data_q <= win_data;
      end
    end
  end

  // A flush in the commit cycle squashes the write that is already in the stage.
  assign rf_write_addr = rf_addr_q;
  assign rf_write_data = rf_data_q;
  assign rf_reg_write  = rf_we_q && !flush;

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .set_valid_i(issue_valid && (issue_rd != ADDR_W'(REG_ZERO))),
    .set_addr_i (issue_rd),
    .clr_valid_i(rf_reg_write),
    .clr_addr_i (rf_addr_q),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

endmodule
